// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the 7-segment MMIO display slice.
//   SEG_W      : width of one segment pattern (gfedcba).
//   SEG_BLANK  : all segments off (active low).
//   HEX_SEG    : active-low pattern for each hex nibble 0..F.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Index is the nibble value; bit 0 is segment a, bit 6 is segment g.
  localparam logic [SEG_W-1:0] HEX_SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
// Combinational hex-nibble to active-low 7-segment decoder.
// Ports:
//   i_nib : 4-bit nibble to display.
//   o_seg : active-low segment pattern, o_seg[0]=a .. o_seg[6]=g.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nib,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg7_mmio_display.sv
// seg7_mmio_display
// Latches words written to the display MMIO address and shows them as hex
// on a multiplexed, active-low 7-segment display, one digit at a time.
// Parameters:
//   DATA_WIDTH  : MMIO word width.
//   DIGITS      : number of digits, 1 <= DIGITS <= DATA_WIDTH/4.
//   REFRESH_DIV : cycles each digit stays enabled, >= 2.
//   BLANK_LZ    : 1 = blank leading zero digits (digit 0 always shown).
// Ports:
//   clk         : system clock, rising edge.
//   rst         : asynchronous active-high reset.
//   mmio_data   : word written by the CPU.
//   mmio_we     : one-cycle write strobe.
//   seg_n       : active-low segments, seg_n[0]=a .. seg_n[6]=g.
//   dp_n        : active-low decimal point, always off.
//   an_n        : active-low digit enables, one-hot-low while scanning.
//   shown_value : currently latched word.
module seg7_mmio_display
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mmio_data,
  input  logic                  mmio_we,
  output logic [SEG_W-1:0]      seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic [DATA_WIDTH-1:0] shown_value
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRESC_W = $clog2(REFRESH_DIV);

  logic [DATA_WIDTH-1:0] r_value;
  logic [PRESC_W-1:0]    r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [SEG_W-1:0]      r_seg;
  logic [DIGITS-1:0]     r_an;
  logic                  r_dp;

  logic                  w_prescWrap;
  logic [3:0]            w_nib;
  logic                  w_blank;
  logic [SEG_W-1:0]      w_seg;

  assign w_prescWrap = (r_presc == PRESC_W'(REFRESH_DIV - 1));

  // Value register; with a held strobe the last cycle's word wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (mmio_we) begin
      r_value <= mmio_data;
    end
  end

  // Prescaler and digit index; the index advances on the prescaler wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_prescWrap) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Nibble mux and leading-zero detection. Walking from the top digit down,
  // zeroRun stays set while every nibble from the top through digit i is
  // zero, which is exactly the blanking condition for digit i.
  always_comb begin
    logic zeroRun;
    zeroRun = 1'b1;
    w_nib   = 4'h0;
    w_blank = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroRun = zeroRun & (r_value[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nib   = r_value[4*i +: 4];
        w_blank = (BLANK_LZ != 0) && (i > 0) && zeroRun;
      end
    end
  end

  hex_to_seg7 u_hexToSeg7 (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Output stage: registered from the current index and value, so a write
  // or digit advance shows up one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_blank ? SEG_BLANK : w_seg;
      r_dp  <= 1'b1;
    end
  end

  assign an_n        = r_an;
  assign seg_n       = r_seg;
  assign dp_n        = r_dp;
  assign shown_value = r_value;

endmodule

// File: tb/tb_seg7_mmio_display.sv
// tb_seg7_mmio_display
// Scoreboard bench for seg7_mmio_display with DIGITS=8, REFRESH_DIV=4,
// BLANK_LZ=1. Stimulus is driven on the falling edge and queues the outputs
// expected after the following rising edge; a monitor samples 2 time units
// after every rising clock edge (and after an asynchronous reset assertion)
// and compares against the head of the queue.
module tb_seg7_mmio_display;

  typedef struct packed {
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] shown;
  } exp_t;

  typedef logic [7:0][6:0] digs_t;

  logic        clk;
  logic        rst;
  logic [31:0] mmio_data;
  logic        mmio_we;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic [31:0] shown_value;

  exp_t  expQ[$];
  int    errors;
  int    checks;
  logic  monEn;

  // Bench-side view of where the scan should be before the next edge.
  int          mPresc;
  int          mIdx;
  logic [31:0] mValue;
  digs_t       curDig;

  seg7_mmio_display #(
    .DATA_WIDTH  (32),
    .DIGITS      (8),
    .REFRESH_DIV (4),
    .BLANK_LZ    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mmio_data   (mmio_data),
    .mmio_we     (mmio_we),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .shown_value (shown_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic digs_t mkDig(input logic [6:0] d0, input logic [6:0] d1,
                                  input logic [6:0] d2, input logic [6:0] d3,
                                  input logic [6:0] d4, input logic [6:0] d5,
                                  input logic [6:0] d6, input logic [6:0] d7);
    digs_t r;
    r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3;
    r[4] = d4; r[5] = d5; r[6] = d6; r[7] = d7;
    return r;
  endfunction

  // Hand-computed per-digit patterns for each word written (BLANK_LZ=1).
  digs_t digZero, dig12345678, digFEDCBA90, digA0, dig0F, dig1, dig2, dig3;
  initial begin
    digZero     = mkDig(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    dig12345678 = mkDig(7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79);
    digFEDCBA90 = mkDig(7'h40, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E);
    digA0       = mkDig(7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    dig0F       = mkDig(7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    dig1        = mkDig(7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    dig2        = mkDig(7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    dig3        = mkDig(7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
  end

  // Compare the sampled outputs against the oldest queued expectation.
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL queue: output sampled with no expectation at t=%0t", $time);
      return;
    end
    e = expQ.pop_front();
    checks++;
    if (an_n !== e.an) begin
      errors++;
      $display("[TB] FAIL an_n: got %h expected %h t=%0t", an_n, e.an, $time);
    end
    checks++;
    if (seg_n !== e.seg) begin
      errors++;
      $display("[TB] FAIL seg_n: got %h expected %h (an_n=%h) t=%0t", seg_n, e.seg, an_n, $time);
    end
    checks++;
    if (dp_n !== e.dp) begin
      errors++;
      $display("[TB] FAIL dp_n: got %b expected %b t=%0t", dp_n, e.dp, $time);
    end
    checks++;
    if (shown_value !== e.shown) begin
      errors++;
      $display("[TB] FAIL shown_value: got %h expected %h t=%0t", shown_value, e.shown, $time);
    end
  endtask

  // Monitor: reset assertion is sampled before the next clock edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #2;
      if (monEn) checkOutput();
    end
  end

  function automatic exp_t resetExp();
    exp_t e;
    e.an    = 8'hFF;
    e.seg   = 7'h7F;
    e.dp    = 1'b1;
    e.shown = 32'h0;
    return e;
  endfunction

  // Called at a falling edge: drive one cycle and queue the outputs
  // expected after the coming rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] data, input digs_t nd);
    exp_t e;
    mmio_we   = we;
    mmio_data = data;
    e.an      = ~(8'h01 << mIdx);
    e.seg     = curDig[mIdx];
    e.dp      = 1'b1;
    e.shown   = we ? data : mValue;
    expQ.push_back(e);
    if (we) begin
      mValue = data;
      curDig = nd;
    end
    if (mPresc == 3) begin
      mPresc = 0;
      mIdx   = (mIdx == 7) ? 0 : mIdx + 1;
    end else begin
      mPresc = mPresc + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, digZero);
  endtask

  task automatic modelReset();
    mPresc = 0;
    mIdx   = 0;
    mValue = 32'h0;
    curDig = digZero;
  endtask

  // Assert reset mid-cycle, hold it across one rising edge, then release.
  task automatic resetPulse();
    mmio_we = 1'b0;
    expQ.push_back(resetExp());
    expQ.push_back(resetExp());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int guard;
    errors    = 0;
    checks    = 0;
    monEn     = 1'b0;
    rst       = 1'b1;
    mmio_we   = 1'b0;
    mmio_data = 32'h0;
    modelReset();

    repeat (2) @(negedge clk);
    expQ.push_back(resetExp());
    monEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    $display("[TB] scan after reset release");
    idle(3);

    $display("[TB] decimal digits with full scan and wrap");
    applyStimulus(1'b1, 32'h12345678, dig12345678);
    idle(34);

    $display("[TB] hex letters");
    applyStimulus(1'b1, 32'hFEDCBA90, digFEDCBA90);
    idle(33);

    $display("[TB] leading-zero blanking");
    applyStimulus(1'b1, 32'h000000A0, digA0);
    idle(33);
    applyStimulus(1'b1, 32'h00000000, digZero);
    idle(33);

    $display("[TB] write on the last-digit wrap edge");
    guard = 0;
    while (!(mIdx == 7 && mPresc == 3) && guard < 40) begin
      idle(1);
      guard++;
    end
    checks++;
    if (!(mIdx == 7 && mPresc == 3)) begin
      errors++;
      $display("[TB] FAIL raceSetup: idx=%0d presc=%0d expected idx=7 presc=3", mIdx, mPresc);
    end
    applyStimulus(1'b1, 32'h0000000F, dig0F);
    idle(5);

    $display("[TB] multi-cycle write");
    applyStimulus(1'b1, 32'h00000001, dig1);
    applyStimulus(1'b1, 32'h00000002, dig2);
    applyStimulus(1'b1, 32'h00000003, dig3);
    idle(10);

    $display("[TB] reset mid-scan");
    applyStimulus(1'b1, 32'h12345678, dig12345678);
    guard = 0;
    while (mIdx != 3 && guard < 40) begin
      idle(1);
      guard++;
    end
    idle(1);
    resetPulse();
    idle(10);

    monEn = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
